ctrl_multiciclo: RTL and testbench
==================================

CTRL_MULTICICLO -- requirements
Module: ctrl_multiciclo

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- instr  in  32  MIPS instruction word (opcode [31:26], funct [5:0]).
- instr_valid  in  1  instr is valid.
- instr_ready  out  1  block accepts instr.
- zero_flag  in  1  ALU Zero_flag.
- mem_ready  in  1  data memory completes the current access.
- alu_op  out  4  ALU code: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10.
- alu_src_b  out  1  0 selects rt, 1 selects immediate.
- imm_zext  out  1  1 zero-extends the immediate, 0 sign-extends it.
- reg_write  out  1  register-file write strobe.
- reg_dst  out  1  1 selects rd, 0 selects rt.
- mem_to_reg  out  1  writeback from memory.
- mem_read  out  1  load request.
- mem_write  out  1  store request.
- pc_write  out  1  PC update strobe.
- pc_src  out  1  1 selects branch target, 0 selects PC+4.
- illegal_instr  out  1  unsupported encoding pulse.
- busy  out  1  instruction in flight.

Function
REQ-003 The block SHALL use these FSM states: FETCH, DECODE, EXEC, WB, MEM_ADDR, MEM_RD, MEM_WR, BRANCH.
REQ-004 instr_ready SHALL be 1 only in FETCH with rst low; when instr_valid & instr_ready, instr SHALL be latched into an internal register and the FSM SHALL move to DECODE.
REQ-005 All control outputs SHALL be Moore decodes of the state and the latched instruction; instr changing after acceptance SHALL have no effect.
REQ-006 R-type decode (opcode 0): funct 0x20/0x22/0x24/0x25/0x26/0x27/0x2A/0x2B/0x04/0x06/0x07 SHALL map to ADD/SUB/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA; for shifts, In1 is rs and In2 is rt.
REQ-007 I-type decode SHALL be:
- addi 0x08 -> ADD, sign-extended immediate.
- andi 0x0C -> AND, zero-extended immediate.
- ori 0x0D -> OR, zero-extended immediate.
- xori 0x0E -> XOR, zero-extended immediate.
- lw 0x23 and sw 0x2B -> ADD, sign-extended immediate.
- beq 0x04 and bne 0x05 -> SUB, alu_src_b=0.
REQ-008 ALU instruction path SHALL be DECODE -> EXEC -> WB -> FETCH; WB asserts reg_write=1 and pc_write=1 for one cycle; reg_dst=1 for R-type, 0 for I-type.
REQ-009 lw path SHALL be DECODE -> MEM_ADDR -> MEM_RD, holding mem_read=1 until mem_ready=1, then WB with mem_to_reg=1 and reg_dst=0.
REQ-010 sw path SHALL be DECODE -> MEM_ADDR -> MEM_WR, holding mem_write=1 until mem_ready=1; on that cycle pc_write=1, then FETCH; reg_write SHALL never assert.
REQ-011 A mem_ready that arrives outside MEM_RD/MEM_WR SHALL be ignored.
REQ-012 Branch path SHALL be DECODE -> BRANCH with alu_op=SUB, sampling zero_flag in BRANCH.
REQ-013 In BRANCH, pc_write=1, with pc_src=1 when (beq & zero_flag) | (bne & ~zero_flag), else 0; next state SHALL be FETCH.
REQ-014 An unsupported opcode or funct SHALL cause a one-cycle illegal_instr pulse in DECODE, pc_write=1, pc_src=0, no register or memory strobe, then FETCH.
REQ-015 alu_op SHALL be ADD (0) in every state where no ALU result is consumed.
REQ-016 busy SHALL be 1 in every state except FETCH.
REQ-017 At most one instruction SHALL be in flight, with no overlap between instructions.

Reset
REQ-018 rst high SHALL force FETCH asynchronously and clear the latched instruction to 0.
REQ-019 While rst is high, all outputs SHALL be 0, including instr_ready.
REQ-020 Reset mid-operation (for example, during MEM_RD wait) SHALL drop mem_read/mem_write immediately, with no write strobes after rst.
REQ-021 The first accept SHALL be possible on the first rising edge after rst falls.

Structure
REQ-022 ALU op codes, opcode/funct constants and state encodings SHALL live in a shared include/package (ula_defs) also used by ula.
REQ-023 Combinational decode (opcode/funct -> class, alu_op, imm_zext, legal) SHALL be a sub-module, ctrl_decode; the FSM and output decode SHALL remain in ctrl_multiciclo.

Verification
REQ-024 Directed scenarios:
- add $3,$1,$2 (0x00221820) accepted -> alu_op=0 in EXEC, reg_write=1, reg_dst=1, pc_write=1 exactly 3 cycles after accept.
- lw with mem_ready delayed 4 cycles -> mem_read held 4 cycles, WB with mem_to_reg=1, total 7 cycles to FETCH.
- beq with zero_flag=1 -> pc_src=1, pc_write=1 in BRANCH; bne with zero_flag=1 -> pc_src=0.
- opcode 0x3F -> illegal_instr one pulse, reg_write=mem_write=0, instr_ready=1 next cycle.
- rst asserted in MEM_WR wait -> mem_write=0 same cycle, instr_ready=1 first cycle after release.
- srav (funct 0x07) -> alu_op=10, andi -> alu_op=2 with imm_zext=1.

Source files
------------

// File: rtl/ula_defs.sv
// ula_defs: shared definitions for the multicycle MIPS control path and the ALU.
// Holds ALU operation codes, opcode/funct constants, FSM state encoding and
// the instruction classes produced by the decoder. No ports (package).
package ula_defs;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WB,
        MEM_ADDR,
        MEM_RD,
        MEM_WR,
        BRANCH
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU_R,
        CL_ALU_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_ILLEGAL
    } instr_class_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0]); shifts are the variable forms (rs, rt)
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decode.
// Ports:
//   i_opcode     in  6  instruction opcode field
//   i_funct      in  6  R-type funct field
//   o_class      out 3  instruction class (instr_class_t encoding)
//   o_alu_op     out 4  ALU operation for the execute/address step
//   o_alu_src_b  out 1  1 selects the immediate as ALU operand B
//   o_imm_zext   out 1  1 zero-extends the immediate
//   o_is_bne     out 1  branch sense: 1 for bne, 0 for beq
//   o_legal      out 1  encoding is supported
module ctrl_decode
    import ula_defs::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_class,
    output logic [3:0] o_alu_op,
    output logic       o_alu_src_b,
    output logic       o_imm_zext,
    output logic       o_is_bne,
    output logic       o_legal
);

    always_comb begin
        o_class     = CL_ILLEGAL;
        o_alu_op    = ALU_ADD;
        o_alu_src_b = 1'b0;
        o_imm_zext  = 1'b0;
        o_is_bne    = (i_opcode == OP_BNE);
        case (i_opcode)
            OP_RTYPE: begin
                o_class = CL_ALU_R;
                case (i_funct)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_OR:   o_alu_op = ALU_OR;
                    FN_XOR:  o_alu_op = ALU_XOR;
                    FN_NOR:  o_alu_op = ALU_NOR;
                    FN_SLT:  o_alu_op = ALU_SLT;
                    FN_SLTU: o_alu_op = ALU_SLTU;
                    FN_SLLV: o_alu_op = ALU_SLL;
                    FN_SRLV: o_alu_op = ALU_SRL;
                    FN_SRAV: o_alu_op = ALU_SRA;
                    default: o_class  = CL_ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                o_class     = CL_ALU_I;
                o_alu_src_b = 1'b1;
            end
            OP_ANDI: begin
                o_class     = CL_ALU_I;
                o_alu_op    = ALU_AND;
                o_alu_src_b = 1'b1;
                o_imm_zext  = 1'b1;
            end
            OP_ORI: begin
                o_class     = CL_ALU_I;
                o_alu_op    = ALU_OR;
                o_alu_src_b = 1'b1;
                o_imm_zext  = 1'b1;
            end
            OP_XORI: begin
                o_class     = CL_ALU_I;
                o_alu_op    = ALU_XOR;
                o_alu_src_b = 1'b1;
                o_imm_zext  = 1'b1;
            end
            OP_LW: begin
                o_class     = CL_LOAD;
                o_alu_src_b = 1'b1;
            end
            OP_SW: begin
                o_class     = CL_STORE;
                o_alu_src_b = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                o_class  = CL_BRANCH;
                o_alu_op = ALU_SUB;
            end
            default: o_class = CL_ILLEGAL;
        endcase
    end

    assign o_legal = (o_class != CL_ILLEGAL);

endmodule

// File: rtl/ctrl_multiciclo.sv
// ctrl_multiciclo: multicycle MIPS control unit (one instruction in flight).
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   instr/instr_valid/instr_ready  instruction handshake (accepted in FETCH)
//   zero_flag         ALU zero result, used in BRANCH
//   mem_ready         data memory access complete (only seen in MEM_RD/MEM_WR)
//   alu_op, alu_src_b, imm_zext    ALU control
//   reg_write, reg_dst, mem_to_reg register-file writeback control
//   mem_read, mem_write            data memory strobes
//   pc_write, pc_src               PC update control
//   illegal_instr     one-cycle pulse for unsupported encodings
//   busy              high in every state except FETCH
module ctrl_multiciclo
    import ula_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        zero_flag,
    input  logic        mem_ready,
    output logic [3:0]  alu_op,
    output logic        alu_src_b,
    output logic        imm_zext,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        mem_read,
    output logic        mem_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        illegal_instr,
    output logic        busy
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_instr;
    logic        w_accept;
    logic [2:0]  w_class;
    logic [3:0]  w_alu_op;
    logic        w_alu_src_b;
    logic        w_imm_zext;
    logic        w_is_bne;
    logic        w_legal;
    logic        w_unused_fields;

    // Register/immediate fields are consumed by the datapath, not here.
    assign w_unused_fields = &{1'b0, r_instr[25:6], w_legal};

    assign w_accept = instr_valid & instr_ready;

    ctrl_decode u_decode (
        .i_opcode    (r_instr[31:26]),
        .i_funct     (r_instr[5:0]),
        .o_class     (w_class),
        .o_alu_op    (w_alu_op),
        .o_alu_src_b (w_alu_src_b),
        .o_imm_zext  (w_imm_zext),
        .o_is_bne    (w_is_bne),
        .o_legal     (w_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
            r_instr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_instr <= instr;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH:    if (w_accept) w_next_state = DECODE;
            DECODE: begin
                case (w_class)
                    CL_ALU_R, CL_ALU_I: w_next_state = EXEC;
                    CL_LOAD, CL_STORE:  w_next_state = MEM_ADDR;
                    CL_BRANCH:          w_next_state = BRANCH;
                    default:            w_next_state = FETCH;
                endcase
            end
            EXEC:     w_next_state = WB;
            WB:       w_next_state = FETCH;
            MEM_ADDR: w_next_state = (w_class == CL_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) w_next_state = WB;
            MEM_WR:   if (mem_ready) w_next_state = FETCH;
            BRANCH:   w_next_state = FETCH;
            default:  w_next_state = FETCH;
        endcase
    end

    // Reset forces FETCH asynchronously, so only instr_ready needs rst gating
    // to keep every output low while rst is held.
    always_comb begin
        instr_ready   = 1'b0;
        alu_op        = ALU_ADD;
        alu_src_b     = 1'b0;
        imm_zext      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        illegal_instr = 1'b0;
        case (r_state)
            FETCH:  instr_ready = ~rst;
            DECODE: begin
                if (w_class == CL_ILLEGAL) begin
                    illegal_instr = 1'b1;
                    pc_write      = 1'b1;
                end
            end
            EXEC, MEM_ADDR: begin
                alu_op    = w_alu_op;
                alu_src_b = w_alu_src_b;
                imm_zext  = w_imm_zext;
            end
            WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                reg_dst    = (w_class == CL_ALU_R);
                mem_to_reg = (w_class == CL_LOAD);
            end
            MEM_RD: mem_read = 1'b1;
            MEM_WR: begin
                mem_write = 1'b1;
                pc_write  = mem_ready;
            end
            BRANCH: begin
                alu_op   = ALU_SUB;
                pc_write = 1'b1;
                pc_src   = w_is_bne ? ~zero_flag : zero_flag;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != FETCH);

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// tb_ctrl_multiciclo: directed self-checking bench for ctrl_multiciclo.
module tb_ctrl_multiciclo;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        zero_flag;
    logic        mem_ready;
    logic [3:0]  alu_op;
    logic        alu_src_b;
    logic        imm_zext;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        pc_write;
    logic        pc_src;
    logic        illegal_instr;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    ctrl_multiciclo dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .zero_flag     (zero_flag),
        .mem_ready     (mem_ready),
        .alu_op        (alu_op),
        .alu_src_b     (alu_src_b),
        .imm_zext      (imm_zext),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .illegal_instr (illegal_instr),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present an instruction in FETCH; it is accepted on the next edge and
    // the input is then scrambled to prove the latched copy is used.
    task automatic accept(input logic [31:0] word);
        check("ready_before_accept", {31'b0, instr_ready}, 32'd1);
        instr       = word;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instr       = 32'hFFFF_FFFF;
        #1;
        check("decode_busy", {31'b0, busy}, 32'd1);
        check("decode_not_ready", {31'b0, instr_ready}, 32'd0);
    endtask

    task automatic run_alu(input string tag, input logic [31:0] word, input logic [3:0] exp_op,
                           input logic exp_srcb, input logic exp_zext, input logic exp_dst);
        accept(word);
        check({tag, "_decode_pcw"}, {31'b0, pc_write}, 32'd0);
        step(); #1;  // EXEC
        check({tag, "_exec_aluop"}, {28'b0, alu_op}, {28'b0, exp_op});
        check({tag, "_exec_srcb"}, {31'b0, alu_src_b}, {31'b0, exp_srcb});
        check({tag, "_exec_zext"}, {31'b0, imm_zext}, {31'b0, exp_zext});
        check({tag, "_exec_regw"}, {31'b0, reg_write}, 32'd0);
        step(); #1;  // WB, three cycles after the accept cycle
        check({tag, "_wb_strobes"}, {29'b0, reg_write, pc_write, mem_to_reg}, 32'b110);
        check({tag, "_wb_regdst"}, {31'b0, reg_dst}, {31'b0, exp_dst});
        check({tag, "_wb_aluop"}, {28'b0, alu_op}, 32'd0);
        step(); #1;  // FETCH
        check({tag, "_back_fetch"}, {30'b0, instr_ready, busy}, 32'b10);
        check({tag, "_fetch_pcw"}, {31'b0, pc_write}, 32'd0);
    endtask

    task automatic run_branch(input string tag, input logic [31:0] word, input logic zf,
                              input logic exp_src);
        accept(word);
        step();      // BRANCH
        zero_flag = zf;
        #1;
        check({tag, "_aluop"}, {28'b0, alu_op}, 32'd1);
        check({tag, "_srcb"}, {31'b0, alu_src_b}, 32'd0);
        check({tag, "_pcw"}, {31'b0, pc_write}, 32'd1);
        check({tag, "_pcsrc"}, {31'b0, pc_src}, {31'b0, exp_src});
        check({tag, "_regw"}, {31'b0, reg_write}, 32'd0);
        step(); #1;  // FETCH
        zero_flag = 1'b0;
        check({tag, "_back_fetch"}, {30'b0, instr_ready, pc_write}, 32'b10);
    endtask

    initial begin
        rst         = 1'b1;
        instr       = 32'h0;
        instr_valid = 1'b1;
        zero_flag   = 1'b0;
        mem_ready   = 1'b0;
        #3;
        check("rst_ready", {31'b0, instr_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_strobes", {26'b0, reg_write, mem_read, mem_write, pc_write, illegal_instr, pc_src}, 32'd0);
        check("rst_aluop", {28'b0, alu_op}, 32'd0);
        step();
        instr_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, instr_ready}, 32'd1);

        // add $3,$1,$2 on the first edge after reset release
        run_alu("add", 32'h0022_1820, 4'd0, 1'b0, 1'b0, 1'b1);

        // lw with mem_ready arriving early (ignored) and then on the 4th MEM_RD cycle
        accept(32'h8C22_0010);
        mem_ready = 1'b1;
        step(); #1;  // MEM_ADDR
        check("lw_addr_aluop", {28'b0, alu_op}, 32'd0);
        check("lw_addr_srcb_zext", {30'b0, alu_src_b, imm_zext}, 32'b10);
        check("lw_addr_memrd", {31'b0, mem_read}, 32'd0);
        step();      // MEM_RD cycle 1
        mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("lw_memrd_hold", {30'b0, mem_read, reg_write}, 32'b10);
            if (i == 4) mem_ready = 1'b1;
            step();
        end
        mem_ready = 1'b0;
        #1;          // WB
        check("lw_wb_strobes", {28'b0, reg_write, pc_write, mem_to_reg, mem_read}, 32'b1110);
        check("lw_wb_regdst", {31'b0, reg_dst}, 32'd0);
        step(); #1;
        check("lw_back_fetch", {30'b0, instr_ready, busy}, 32'b10);

        // branches
        run_branch("beq_z1", 32'h1022_0003, 1'b1, 1'b1);
        run_branch("bne_z1", 32'h1422_0003, 1'b1, 1'b0);
        run_branch("bne_z0", 32'h1422_0003, 1'b0, 1'b1);

        // illegal opcode 0x3F
        accept(32'hFC00_0000);
        check("ill_op_pulse", {31'b0, illegal_instr}, 32'd1);
        check("ill_op_pc", {30'b0, pc_write, pc_src}, 32'b10);
        check("ill_op_strobes", {29'b0, reg_write, mem_write, mem_read}, 32'd0);
        step(); #1;
        check("ill_op_next", {30'b0, illegal_instr, instr_ready}, 32'b01);

        // illegal R-type funct 0x3F
        accept(32'h0000_003F);
        check("ill_fn_pulse", {31'b0, illegal_instr}, 32'd1);
        step(); #1;
        check("ill_fn_next", {30'b0, illegal_instr, instr_ready}, 32'b01);

        // sw completing normally
        accept(32'hAC22_0004);
        step(); #1;  // MEM_ADDR
        check("sw_addr_srcb", {31'b0, alu_src_b}, 32'd1);
        step(); #1;  // MEM_WR
        check("sw_wait", {29'b0, mem_write, pc_write, reg_write}, 32'b100);
        mem_ready = 1'b1;
        #1;
        check("sw_done", {29'b0, mem_write, pc_write, reg_write}, 32'b110);
        step();
        mem_ready = 1'b0;
        #1;
        check("sw_back_fetch", {30'b0, instr_ready, reg_write}, 32'b10);

        // sw interrupted by reset while waiting in MEM_WR
        accept(32'hAC22_0004);
        step(); step(); #1;
        check("swr_wait", {31'b0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        check("swr_rst_drop", {28'b0, mem_write, pc_write, reg_write, busy}, 32'd0);
        check("swr_rst_ready", {31'b0, instr_ready}, 32'd0);
        step(); #1;
        check("swr_rst_hold", {29'b0, mem_write, instr_ready, busy}, 32'd0);
        rst = 1'b0;
        #1;
        check("swr_release_ready", {31'b0, instr_ready}, 32'd1);

        // srav and andi
        run_alu("srav", 32'h0022_1807, 4'd10, 1'b0, 1'b0, 1'b1);
        run_alu("andi", 32'h3022_FFFF, 4'd2, 1'b1, 1'b1, 1'b0);
        run_alu("addi", 32'h2022_FFFF, 4'd0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
